// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter with a start/busy/done handshake; latency BIN_W+1 cycles.
// Optional BCD_SAT_EN: overflowing inputs saturate bcd to all nines and raise ovf.
module seq_bin2bcd #(
   parameter int BIN_W  = 10,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int ACC_W = 4 * (DIGITS + 1);
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t              state_q;
   logic [ACC_W-1:0]    acc_q;
   logic [BIN_W-1:0]    sr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                busy_q;
   logic                done_q;
   logic [4*DIGITS-1:0] bcd_q;
   logic                ovf_q;

   logic [ACC_W-1:0]    acc_adj;
   logic [4*DIGITS-1:0] bcd_d;
   logic                ovf_d;

   // Add-3 correction on every digit, including the spare top digit that catches overflow.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
`ifdef BCD_SAT_EN
      ovf_d = |acc_q[ACC_W-1:4*DIGITS];
      bcd_d = ovf_d ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
`else
      ovf_d = 1'b0;
      bcd_d = acc_q[4*DIGITS-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         sr_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  sr_q    <= bin;
                  acc_q   <= '0;
                  cnt_q   <= CNT_W'(BIN_W);
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               {acc_q, sr_q} <= {acc_adj, sr_q} << 1;
               cnt_q         <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  busy_q  <= 1'b0;
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               bcd_q   <= bcd_d;
               ovf_q   <= ovf_d;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Scoreboard bench for seq_bin2bcd: expected {ovf,bcd} queued at each accepted start, popped at done.
module tb_seq_bin2bcd;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  bin;
   logic        busy;
   logic        done;
   logic [11:0] bcd;
   logic        ovf;

   int          n_cmp;
   int          n_err;
   logic [12:0] sb[$];

   seq_bin2bcd #(.BIN_W(10), .DIGITS(3)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] model(int v);
      logic [3:0] d0, d1, d2;
`ifdef BCD_SAT_EN
      if (v > 999) return {1'b1, 12'h999};
`endif
      d0 = 4'(v % 10);
      d1 = 4'((v / 10) % 10);
      d2 = 4'((v / 100) % 10);
      return {1'b0, d2, d1, d0};
   endfunction

   // Drives a one-cycle start; returns at the negedge right after the accepting edge.
   task automatic start_conv(input int v, input bit expect_accept);
      @(negedge clk);
      start = 1'b1;
      bin   = 10'(v);
      if (expect_accept) sb.push_back(model(v));
      @(negedge clk);
      start = 1'b0;
      bin   = 10'($urandom_range(1023));
   endtask

   // Counts edges after the accepting edge until done is seen (bounded).
   task automatic wait_done(output int e, output int busy_cnt);
      e = 0;
      busy_cnt = 0;
      while (done !== 1'b1 && e < 40) begin
         if (busy === 1'b1) busy_cnt++;
         @(negedge clk);
         e++;
      end
   endtask

   task automatic test_reset();
      logic [12:0] exp;
      rst = 1'b0; start = 1'b0; bin = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, ovf, bcd} !== 15'd0) begin
         n_err++; $display("FAIL reset_state: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy, done, ovf, bcd);
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, ovf, bcd} !== 15'd0) begin
         n_err++; $display("FAIL reset_release: got busy=%b done=%b ovf=%b bcd=%h, want all 0", busy, done, ovf, bcd);
      end
      // Conversion of zero right after reset
      begin
         int e, bc;
         start_conv(0, 1'b1);
         wait_done(e, bc);
         n_cmp++;
         if (e !== 11) begin n_err++; $display("FAIL zero_latency: got %0d want 11", e); end
         exp = sb.pop_front();
         n_cmp++;
         if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL zero_result: got %h want %h", {ovf, bcd}, exp); end
      end
   endtask

   task automatic test_basic();
      int e, bc;
      logic [12:0] exp;
      start_conv(537, 1'b1);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_start: got %b want 1", busy); end
      wait_done(e, bc);
      n_cmp++;
      if (bc !== 10) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 10", bc); end
      n_cmp++;
      if (e !== 11) begin n_err++; $display("FAIL basic_latency: got %0d want 11", e); end
      exp = sb.pop_front();
      n_cmp++;
      if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL basic_result: got %h want %h", {ovf, bcd}, exp); end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse: got %b want 0", done); end
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({ovf, bcd} !== exp || busy !== 1'b0) begin
         n_err++; $display("FAIL basic_hold: got bcd=%h busy=%b want %h busy=0", {ovf, bcd}, busy, exp);
      end
   endtask

   task automatic test_back_to_back();
      int e, bc;
      logic [12:0] exp;
      start_conv(999, 1'b1);
      wait_done(e, bc);
      exp = sb.pop_front();
      n_cmp++;
      if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL b2b_first: got %h want %h", {ovf, bcd}, exp); end
      // Request issued during the done cycle must be taken at the very next edge.
      start = 1'b1; bin = 10'd42; sb.push_back(model(42));
      @(negedge clk);
      start = 1'b0; bin = 10'd777;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
      wait_done(e, bc);
      n_cmp++;
      if (e !== 11) begin n_err++; $display("FAIL b2b_latency: got %0d want 11", e); end
      exp = sb.pop_front();
      n_cmp++;
      if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL b2b_second: got %h want %h", {ovf, bcd}, exp); end
   endtask

   task automatic test_ignore_start();
      int ndone, at;
      logic [12:0] exp;
      start_conv(100, 1'b1);
      ndone = 0; at = -1;
      for (int e = 0; e < 26; e++) begin
         if (done === 1'b1) begin
            ndone++;
            if (at < 0) begin
               at = e;
               exp = sb.pop_front();
               n_cmp++;
               if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL ignore_result: got %h want %h", {ovf, bcd}, exp); end
            end
         end
         start = (e == 2 || e == 10);
         bin   = 10'd777;
         @(negedge clk);
      end
      start = 1'b0;
      n_cmp++;
      if (ndone !== 1 || at !== 11) begin
         n_err++; $display("FAIL ignore_done_count: got %0d dones first at %0d want 1 at 11", ndone, at);
      end
   endtask

   task automatic test_overflow();
      int e, bc;
      logic [12:0] exp;
      start_conv(1023, 1'b1);
      wait_done(e, bc);
      exp = sb.pop_front();
      n_cmp++;
      if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL overflow_1023: got %h want %h", {ovf, bcd}, exp); end
      start_conv(1000, 1'b1);
      wait_done(e, bc);
      exp = sb.pop_front();
      n_cmp++;
      if ({ovf, bcd} !== exp) begin n_err++; $display("FAIL overflow_1000: got %h want %h", {ovf, bcd}, exp); end
   endtask

   task automatic test_reset_abort();
      int e, bc, ndone;
      start_conv(640, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, ovf, bcd} !== 15'd0) begin
         n_err++; $display("FAIL abort_reset_state: got busy=%b done=%b ovf=%b bcd=%h want all 0", busy, done, ovf, bcd);
      end
      rst = 1'b1;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      n_cmp++;
      if (ndone !== 0 || busy !== 1'b0 || bcd !== 12'h000) begin
         n_err++; $display("FAIL abort_no_done: got dones=%0d busy=%b bcd=%h want 0 0 000", ndone, busy, bcd);
      end
      start_conv(640, 1'b1);
      wait_done(e, bc);
      n_cmp++;
      if ({ovf, bcd} !== sb.pop_front()) begin n_err++; $display("FAIL abort_restart: got %h want 0640", {ovf, bcd}); end
   endtask

   task automatic test_random();
      int e, bc, v;
      logic [12:0] exp;
      for (int i = 0; i < 8; i++) begin
         v = $urandom_range(1023);
         start_conv(v, 1'b1);
         wait_done(e, bc);
         exp = sb.pop_front();
         n_cmp++;
         if ({ovf, bcd} !== exp || e !== 11) begin
            n_err++; $display("FAIL random_%0d: bin=%0d got %h lat %0d want %h lat 11", i, v, {ovf, bcd}, e, exp);
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_start();
      test_overflow();
      test_reset_abort();
      test_random();
      n_cmp++;
      if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_empty: got %0d left want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
